// File: rtl/hba_pkg.sv
// Shared HBA definitions: address widths, command-byte field positions and
// the command master's FSM state encoding.
package hba_pkg;

    localparam int unsigned HBA_DBUS_W    = 8;
    localparam int unsigned HBA_PERIPH_AW = 4;
    localparam int unsigned HBA_REG_AW    = 8;
    localparam int unsigned HBA_CMD_W     = 8;

    // byte0 = {rnw, len-1[2:0], periph[3:0]}
    localparam int unsigned RNW_BIT    = 7;
    localparam int unsigned LEN_MSB    = 6;
    localparam int unsigned LEN_LSB    = 4;
    localparam int unsigned PERIPH_MSB = 3;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGetReg  = 3'd1,
        StGetData = 3'd2,
        StXfer    = 3'd3,
        StGap     = 3'd4,
        StSendRsp = 3'd5
    } hba_state_e;

    // Burst length 1..8 decoded from the length-minus-one field of byte0.
    function automatic logic [3:0] cmd_len(input logic [HBA_CMD_W-1:0] b);
        return {1'b0, b[LEN_MSB:LEN_LSB]} + 4'd1;
    endfunction

endpackage

// File: rtl/hba_ack_timer.sv
// Loadable down-counter that strobes expired_o on its last enabled cycle;
// used by HBA masters to bound the wait for a slave acknowledge.
module hba_ack_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [Width-1:0] load_val_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - Width'(1);
        end
    end

    assign expired_o = en_i && !load_i && (count_q == '0);

endmodule

// File: rtl/hba_cmd_master.sv
// HBA bus master: decodes a byte-stream command channel into HBA read/write
// bursts with register auto-increment and returns read data as bytes.
module hba_cmd_master
    import hba_pkg::*;
#(
    parameter int unsigned DBUS_WIDTH        = HBA_DBUS_W,
    parameter int unsigned PERIPH_ADDR_WIDTH = HBA_PERIPH_AW,
    parameter int unsigned REG_ADDR_WIDTH    = HBA_REG_AW,
    parameter int unsigned TIMEOUT_CYCLES    = 255,
    parameter logic [7:0]  TIMEOUT_DATA      = 8'hEE
) (
    input  logic                                        hba_clk,
    input  logic                                        hba_reset,
    input  logic [HBA_CMD_W-1:0]                        cmd_data,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    output logic [7:0]                                  rsp_data,
    output logic                                        rsp_valid,
    input  logic                                        rsp_ready,
    output logic                                        hba_rnw,
    output logic                                        hba_select,
    output logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
    output logic [DBUS_WIDTH-1:0]                       hba_dbus,
    input  logic [DBUS_WIDTH-1:0]                       hba_dbus_slave,
    input  logic                                        hba_xferack,
    output logic                                        timeout_err
);

    localparam int unsigned AW     = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH;
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);

    hba_state_e          state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [7:0]          rsp_data_q;
    logic                rnw_q;
    logic                select_q;
    logic [AW-1:0]       abus_q;
    logic [DBUS_WIDTH-1:0] dbus_q;
    logic                timeout_err_q;
    logic [3:0]          rem_q;

    logic cmd_accept;
    logic tmr_expired;

    assign cmd_accept = cmd_valid && cmd_ready_q;

    // Timer sits preloaded outside XFER so every transfer gets the full window.
    hba_ack_timer #(
        .Width(TimerW)
    ) u_ack_timer (
        .clk_i     (hba_clk),
        .rst_i     (hba_reset),
        .load_i    (state_q != StXfer),
        .en_i      (state_q == StXfer),
        .load_val_i(TimerW'(TIMEOUT_CYCLES - 1)),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rnw_q         <= 1'b0;
            select_q      <= 1'b0;
            abus_q        <= '0;
            dbus_q        <= '0;
            timeout_err_q <= 1'b0;
            rem_q         <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_accept) begin
                        rnw_q                      <= cmd_data[RNW_BIT];
                        rem_q                      <= cmd_len(cmd_data);
                        abus_q[AW-1:REG_ADDR_WIDTH] <=
                            PERIPH_ADDR_WIDTH'(cmd_data[PERIPH_MSB:0]);
                        state_q                    <= StGetReg;
                    end
                end
                StGetReg: begin
                    if (cmd_accept) begin
                        abus_q[REG_ADDR_WIDTH-1:0] <= REG_ADDR_WIDTH'(cmd_data);
                        if (rnw_q) begin
                            cmd_ready_q <= 1'b0;
                            select_q    <= 1'b1;
                            state_q     <= StXfer;
                        end else begin
                            state_q <= StGetData;
                        end
                    end
                end
                StGetData: begin
                    if (cmd_accept) begin
                        dbus_q      <= DBUS_WIDTH'(cmd_data);
                        cmd_ready_q <= 1'b0;
                        select_q    <= 1'b1;
                        state_q     <= StXfer;
                    end
                end
                StXfer: begin
                    // Ack wins over a simultaneous expiry.
                    if (hba_xferack || tmr_expired) begin
                        select_q <= 1'b0;
                        dbus_q   <= '0;
                        rem_q    <= rem_q - 4'd1;
                        state_q  <= StGap;
                        if (!hba_xferack) begin
                            timeout_err_q <= 1'b1;
                        end
                        if (rnw_q) begin
                            rsp_data_q <= hba_xferack ? 8'(hba_dbus_slave) : TIMEOUT_DATA;
                        end
                    end
                end
                StGap: begin
                    abus_q[REG_ADDR_WIDTH-1:0] <=
                        abus_q[REG_ADDR_WIDTH-1:0] + REG_ADDR_WIDTH'(1);
                    if (rnw_q) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= StSendRsp;
                    end else if (rem_q != '0) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= StGetData;
                    end else begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StSendRsp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rem_q != '0) begin
                            select_q <= 1'b1;
                            state_q  <= StXfer;
                        end else begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign hba_rnw     = rnw_q;
    assign hba_select  = select_q;
    assign hba_abus    = abus_q;
    assign hba_dbus    = dbus_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hba_cmd_master.sv
// Randomised bench for hba_cmd_master: a reference model queues expected bus
// transfers and response bytes; monitors compare them as the DUT produces them.
module tb_hba_cmd_master;

    localparam int unsigned TO = 16;

    logic        hba_clk = 1'b0;
    logic        hba_reset = 1'b1;
    logic [7:0]  cmd_data = 8'h00;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        hba_rnw;
    logic        hba_select;
    logic [11:0] hba_abus;
    logic [7:0]  hba_dbus;
    logic [7:0]  hba_dbus_slave;
    logic        hba_xferack;
    logic        timeout_err;

    always #5 hba_clk = ~hba_clk;

    hba_cmd_master #(
        .DBUS_WIDTH       (8),
        .PERIPH_ADDR_WIDTH(4),
        .REG_ADDR_WIDTH   (8),
        .TIMEOUT_CYCLES   (TO),
        .TIMEOUT_DATA     (8'hEE)
    ) dut (
        .hba_clk       (hba_clk),
        .hba_reset     (hba_reset),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .rsp_data      (rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .hba_rnw       (hba_rnw),
        .hba_select    (hba_select),
        .hba_abus      (hba_abus),
        .hba_dbus      (hba_dbus),
        .hba_dbus_slave(hba_dbus_slave),
        .hba_xferack   (hba_xferack),
        .timeout_err   (timeout_err)
    );

    typedef struct packed {
        logic        rnw;
        logic [11:0] addr;
        logic [7:0]  data;
        logic        to;
    } xfer_t;

    xfer_t      exp_xfer_q[$];
    logic [7:0] exp_rsp_q[$];
    logic [7:0] mdl_mem[256];
    int checks = 0;
    int errors = 0;
    int tout_seen = 0;
    int tout_exp = 0;
    bit hold_ready = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    // Register-bank slave at periph 5 with random ack latency and an
    // occasional ack held one cycle too long.
    logic [7:0] slv_mem[256];
    logic       slv_ack = 1'b0;
    logic       slv_hold = 1'b0;
    int         slv_wait = 0;
    bit         slv_inited = 1'b0;

    always @(posedge hba_clk) begin
        if (hba_reset) begin
            slv_ack  <= 1'b0;
            slv_hold <= 1'b0;
            slv_wait <= 0;
            if (!slv_inited) begin
                for (int i = 0; i < 256; i++) slv_mem[i] <= 8'h00;
                slv_inited <= 1'b1;
            end
        end else if (slv_ack) begin
            if (slv_hold) slv_hold <= 1'b0;
            else begin
                slv_ack  <= 1'b0;
                slv_wait <= int'($urandom_range(0, 2));
            end
        end else if (hba_select && hba_abus[11:8] == 4'd5) begin
            if (slv_wait == 0) begin
                slv_ack  <= 1'b1;
                slv_hold <= ($urandom_range(0, 3) == 0);
                if (!hba_rnw) slv_mem[hba_abus[7:0]] <= hba_dbus;
            end else begin
                slv_wait <= slv_wait - 1;
            end
        end
    end

    assign hba_xferack    = slv_ack;
    assign hba_dbus_slave = slv_ack ? slv_mem[hba_abus[7:0]] : 8'h00;

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge hba_clk);
            #1;
            rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: bus transfers and response bytes.
    logic        prev_sel = 1'b0;
    bit          have_cur = 1'b0;
    bit          stable;
    bit          stall = 1'b0;
    int          dur;
    xfer_t       cur;
    logic [11:0] st_abus;
    logic [7:0]  st_dbus;
    logic [7:0]  held_data;
    logic [7:0]  exp_b;

    always @(negedge hba_clk) begin
        if (timeout_err) tout_seen++;
        if (hba_reset) begin
            prev_sel = 1'b0;
            have_cur = 1'b0;
            stall    = 1'b0;
        end else begin
            if (hba_select && !prev_sel) begin
                check("xfer_cmd_ready_low", cmd_ready, 0);
                check("xfer_no_rsp_pending", rsp_valid, 0);
                if (exp_xfer_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got addr %h, required none", hba_abus);
                    have_cur = 1'b0;
                end else begin
                    cur = exp_xfer_q.pop_front();
                    have_cur = 1'b1;
                    check("xfer_rnw", hba_rnw, cur.rnw);
                    check("xfer_addr", hba_abus, cur.addr);
                    check("xfer_dbus", hba_dbus, cur.rnw ? 8'h00 : cur.data);
                end
                dur = 1;
                st_abus = hba_abus;
                st_dbus = hba_dbus;
                stable = 1'b1;
            end else if (hba_select) begin
                dur++;
                if (hba_abus !== st_abus || hba_dbus !== st_dbus || cmd_ready) stable = 1'b0;
            end else if (prev_sel && have_cur) begin
                check("xfer_stable", stable, 1);
                check("gap_dbus_zero", hba_dbus, 0);
                check("timeout_err_pulse", timeout_err, cur.to);
                if (cur.to) begin
                    check("timeout_select_cycles", dur, TO);
                    tout_exp++;
                end
                have_cur = 1'b0;
            end
            prev_sel = hba_select;

            if (stall && rsp_valid) check("rsp_data_held", rsp_data, held_data);
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %h, required none", rsp_data);
                end else begin
                    exp_b = exp_rsp_q.pop_front();
                    check("rsp_data", rsp_data, exp_b);
                end
                stall = 1'b0;
            end else if (rsp_valid) begin
                stall = 1'b1;
                held_data = rsp_data;
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 3000) begin
            @(negedge hba_clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: byte %h not taken, required accept", b);
        end
        @(negedge hba_clk);
        cmd_valid = 1'b0;
    endtask

    // Reference model: expands a command into its transfers and responses.
    task automatic do_cmd(input bit rnw, input int len, input logic [3:0] periph,
                          input logic [7:0] rg, input int base);
        xfer_t      x;
        logic [7:0] wd[$];
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            a = rg + 8'(i);
            x.rnw  = rnw;
            x.addr = {periph, a};
            x.to   = (periph != 4'd5);
            if (rnw) begin
                x.data = 8'h00;
                exp_rsp_q.push_back((periph == 4'd5) ? mdl_mem[a] : 8'hEE);
            end else begin
                d = (base < 0) ? 8'($urandom) : 8'(base + i);
                x.data = d;
                wd.push_back(d);
                if (periph == 4'd5) mdl_mem[a] = d;
            end
            exp_xfer_q.push_back(x);
        end
        send_byte({rnw, 3'(len - 1), periph});
        send_byte(rg);
        foreach (wd[i]) send_byte(wd[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_xfer_q.size() != 0 || exp_rsp_q.size() != 0) && n < 5000) begin
            @(negedge hba_clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d xfers %0d rsps left, required 0",
                     exp_xfer_q.size(), exp_rsp_q.size());
        end
        repeat (TO + 8) @(negedge hba_clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        hba_reset = 1'b1;
        repeat (3) @(negedge hba_clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_select", hba_select, 0);
        check("rst_rnw", hba_rnw, 0);
        check("rst_abus", hba_abus, 0);
        check("rst_dbus", hba_dbus, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(posedge hba_clk);
        #1 hba_reset = 1'b0;
        @(negedge hba_clk);

        do_cmd(1'b0, 1, 4'd5, 8'h01, 8'h12);
        do_cmd(1'b1, 1, 4'd5, 8'h01, 0);
        do_cmd(1'b0, 4, 4'd5, 8'hFE, 8'hA0);
        wait_idle();

        // Backpressure: response must wait, no second transfer meanwhile.
        hold_ready = 1'b1;
        do_cmd(1'b1, 2, 4'd5, 8'h00, 0);
        n = 0;
        while (!rsp_valid && n < 500) begin
            @(negedge hba_clk);
            n++;
        end
        check("bp_rsp_arrives", rsp_valid, 1);
        repeat (10) begin
            @(negedge hba_clk);
            check("bp_valid_held", rsp_valid, 1);
            check("bp_no_next_xfer", hba_select, 0);
        end
        hold_ready = 1'b0;
        wait_idle();

        do_cmd(1'b1, 1, 4'd9, 8'h33, 0);
        wait_idle();

        // Reset during a transfer, then a normal read.
        do_cmd(1'b1, 1, 4'd9, 8'h10, 0);
        n = 0;
        while (!hba_select && n < 200) begin
            @(negedge hba_clk);
            n++;
        end
        check("mid_reset_select_seen", hba_select, 1);
        repeat (3) @(negedge hba_clk);
        @(posedge hba_clk);
        #1 hba_reset = 1'b1;
        @(posedge hba_clk);
        @(negedge hba_clk);
        check("mid_reset_select", hba_select, 0);
        check("mid_reset_cmd_ready", cmd_ready, 0);
        check("mid_reset_rsp_valid", rsp_valid, 0);
        exp_xfer_q.delete();
        exp_rsp_q.delete();
        @(posedge hba_clk);
        #1 hba_reset = 1'b0;
        @(negedge hba_clk);
        do_cmd(1'b1, 1, 4'd5, 8'h01, 0);
        wait_idle();

        repeat (40) begin
            do_cmd(bit'($urandom_range(0, 1)), int'($urandom_range(1, 8)),
                   ($urandom_range(0, 7) == 0) ? 4'd9 : 4'd5, 8'($urandom), -1);
        end
        wait_idle();

        check("end_xfer_queue_empty", exp_xfer_q.size(), 0);
        check("end_rsp_queue_empty", exp_rsp_q.size(), 0);
        check("timeout_pulse_count", tout_seen, tout_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
